// File: rtl/cnn_top_udiv_9ns_4ns_seq_pkg.sv
// Shared types and constants for the iterative unsigned divider.
// State encoding, default widths and the divide-by-zero quotient.
package cnn_top_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DIVIDEND_WIDTH_DEF = 9;
    localparam int DIVISOR_WIDTH_DEF  = 4;

    // Sliced to the dividend width at the point of use.
    localparam logic [31:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/cnn_top_udiv_9ns_4ns_seq_if.sv
// Operand and result handshake bundle for the divider.
// master: producer/consumer side, slave: divider side.
interface cnn_top_udiv_9ns_4ns_seq_if #(
    parameter int DIVIDEND_WIDTH = 9,
    parameter int DIVISOR_WIDTH  = 4
);
    logic                      in_vld;
    logic                      in_rdy;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_vld;
    logic                      out_rdy;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;

    modport master (
        output in_vld,
        input  in_rdy,
        output dividend,
        output divisor,
        input  out_vld,
        output out_rdy,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_vld,
        output in_rdy,
        input  dividend,
        input  divisor,
        output out_vld,
        input  out_rdy,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/cnn_top_udiv_9ns_4ns_seq_step.sv
// One restoring radix-2 iteration: shift in a bit, trial subtract,
// keep the difference when it does not underflow.
module cnn_top_udiv_step #(
    parameter int DIVISOR_WIDTH = 4
) (
    input  logic [DIVISOR_WIDTH:0]   prem,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH:0]   prem_nxt,
    output logic                     q_bit
);
    localparam int DSW = DIVISOR_WIDTH;

    logic [DSW+1:0] sh;
    logic [DSW:0]   diff;
    logic           ge;

    // prem < divisor holds between steps, so a taken difference
    // always fits back into DSW+1 bits.
    assign sh   = {prem, bit_in};
    assign ge   = sh >= {2'b00, divisor};
    assign diff = sh[DSW:0] - {1'b0, divisor};

    assign prem_nxt = ge ? diff : sh[DSW:0];
    assign q_bit    = ge;
endmodule

// File: rtl/cnn_top_udiv_9ns_4ns_seq.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// CNN_TOP_UDIV_ZERO_SKIP_EN: finish at once when dividend < divisor.
module cnn_top_udiv_9ns_4ns_seq
    import cnn_top_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
    parameter int DIVISOR_WIDTH  = DIVISOR_WIDTH_DEF
) (
    input logic                      ap_clk,
    input logic                      ap_rst_n,
    cnn_top_udiv_9ns_4ns_seq_if.slave bus
);
    localparam int DW        = DIVIDEND_WIDTH;
    localparam int DSW       = DIVISOR_WIDTH;
    localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

    state_t               state;
    logic [DW-1:0]        shreg;
    logic [DSW-1:0]       dvs;
    logic [DSW:0]         prem;
    logic [CNT_WIDTH-1:0] cnt;

    logic                 in_rdy_q;
    logic                 out_vld_q;
    logic [DW-1:0]        quo_q;
    logic [DSW-1:0]       rem_q;
    logic                 dbz_q;

    logic [DSW:0]         prem_nxt;
    logic                 q_bit;
    logic                 skip;

    assign bus.in_rdy      = in_rdy_q;
    assign bus.out_vld     = out_vld_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

`ifdef CNN_TOP_UDIV_ZERO_SKIP_EN
    assign skip = bus.dividend < DW'(bus.divisor);
`else
    assign skip = 1'b0;
`endif

    cnn_top_udiv_step #(
        .DIVISOR_WIDTH (DSW)
    ) u_step (
        .prem     (prem),
        .bit_in   (shreg[DW-1]),
        .divisor  (dvs),
        .prem_nxt (prem_nxt),
        .q_bit    (q_bit)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            dvs       <= '0;
            prem      <= '0;
            cnt       <= '0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_vld && in_rdy_q) begin
                        in_rdy_q <= 1'b0;
                        shreg    <= bus.dividend;
                        dvs      <= bus.divisor;
                        prem     <= '0;
                        cnt      <= CNT_WIDTH'(DW);
                        if (bus.divisor == '0) begin
                            state <= DONE;
                            quo_q <= DBZ_QUOTIENT[DW-1:0];
                            rem_q <= bus.dividend[DSW-1:0];
                            dbz_q <= 1'b1;
                        end else if (skip) begin
                            state <= DONE;
                            quo_q <= '0;
                            rem_q <= bus.dividend[DSW-1:0];
                            dbz_q <= 1'b0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    prem  <= prem_nxt;
                    shreg <= {shreg[DW-2:0], q_bit};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_WIDTH'(1)) begin
                        state <= DONE;
                        quo_q <= {shreg[DW-2:0], q_bit};
                        rem_q <= prem_nxt[DSW-1:0];
                        dbz_q <= 1'b0;
                    end
                end
                DONE: begin
                    // Result registers settle on entry; valid follows a cycle later.
                    if (!out_vld_q) begin
                        out_vld_q <= 1'b1;
                    end else if (bus.out_rdy) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_top_udiv_9ns_4ns_seq.sv
// Self-checking bench for the iterative unsigned divider.
// Vector table plus scoreboard; reset abort and stall sequences.
module tb_cnn_top_udiv_9ns_4ns_seq;

    typedef struct {
        logic [8:0] dvd;
        logic [3:0] dvs;
        logic [8:0] q;
        logic [3:0] r;
        logic       dbz;
        int         hold;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t sb[$];
    vec_t tbl[12];

    cnn_top_udiv_9ns_4ns_seq_if #(
        .DIVIDEND_WIDTH (9),
        .DIVISOR_WIDTH  (4)
    ) bus ();

    cnn_top_udiv_9ns_4ns_seq #(
        .DIVIDEND_WIDTH (9),
        .DIVISOR_WIDTH  (4)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic int lat_of(input vec_t v);
        if (v.dvs == 4'd0) return 1;
`ifdef CNN_TOP_UDIV_ZERO_SKIP_EN
        if (v.dvd < {5'd0, v.dvs}) return 1;
`endif
        return 10;
    endfunction

    // Pop and compare on every accepted result.
    always @(negedge clk) begin
        if (rst_n && bus.out_vld && bus.out_rdy) begin
            if (sb.size() == 0) begin
                chk("spurious_result", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = sb.pop_front();
                chk("quotient", 32'(bus.quotient), 32'(e.q));
                chk("remainder", 32'(bus.remainder), 32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic run_op(input vec_t v);
        int  n;
        bit  seen;
        bit  rdy_ok;
        bit  stable;
        n = 0;
        while (!bus.in_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_rdy_idle", 32'(bus.in_rdy), 32'd1);
        bus.dividend = v.dvd;
        bus.divisor  = v.dvs;
        bus.in_vld   = 1'b1;
        bus.out_rdy  = (v.hold == 0);
        sb.push_back(v);
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        n      = 0;
        seen   = 1'b0;
        rdy_ok = 1'b1;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (bus.in_rdy) rdy_ok = 1'b0;
            if (bus.out_vld) seen = 1'b1;
        end
        chk("latency", 32'(n), 32'(lat_of(v)));
        chk("in_rdy_low_busy", 32'(rdy_ok), 32'd1);
        if (v.hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                if (!bus.out_vld || bus.quotient !== v.q ||
                    bus.remainder !== v.r || bus.div_by_zero !== v.dbz)
                    stable = 1'b0;
                if (i < v.hold - 1) begin
                    @(posedge clk); #1;
                end
            end
            chk("hold_stable", 32'(stable), 32'd1);
            bus.out_rdy = 1'b1;
        end
        @(posedge clk); #1;
        chk("back_to_idle", 32'({bus.in_rdy, bus.out_vld}), 32'd2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  quiet;
        total = 0;
        bad   = 0;
        tbl[0]  = '{9'd300, 4'd7,  9'd42,  4'd6,  1'b0, 0};
        tbl[1]  = '{9'd511, 4'd1,  9'd511, 4'd0,  1'b0, 0};
        tbl[2]  = '{9'd255, 4'd15, 9'd17,  4'd0,  1'b0, 0};
        tbl[3]  = '{9'd5,   4'd0,  9'd511, 4'd5,  1'b1, 0};
        tbl[4]  = '{9'd100, 4'd9,  9'd11,  4'd1,  1'b0, 6};
        tbl[5]  = '{9'd3,   4'd12, 9'd0,   4'd3,  1'b0, 0};
        tbl[6]  = '{9'd0,   4'd5,  9'd0,   4'd0,  1'b0, 0};
        tbl[7]  = '{9'd511, 4'd15, 9'd34,  4'd1,  1'b0, 0};
        tbl[8]  = '{9'd17,  4'd0,  9'd511, 4'd1,  1'b1, 2};
        tbl[9]  = '{9'd8,   4'd8,  9'd1,   4'd0,  1'b0, 0};
        tbl[10] = '{9'd200, 4'd13, 9'd15,  4'd5,  1'b0, 0};
        tbl[11] = '{9'd1,   4'd1,  9'd1,   4'd0,  1'b0, 0};

        rst_n        = 1'b0;
        bus.in_vld   = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        bus.out_rdy  = 1'b1;
        #12;
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_quotient", 32'(bus.quotient), 32'd0);
        chk("rst_remainder", 32'(bus.remainder), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_op(tbl[i]);

        // Abort 400/3 part way through with an async reset pulse.
        bus.dividend = 9'd400;
        bus.divisor  = 4'd3;
        bus.in_vld   = 1'b1;
        @(posedge clk); #1;
        bus.in_vld = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_busy", 32'(bus.in_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_in_rdy", 32'(bus.in_rdy), 32'd1);
        chk("abort_out_vld", 32'(bus.out_vld), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        quiet = 1'b1;
        for (n = 0; n < 14; n++) begin
            @(posedge clk); #1;
            if (bus.out_vld || !bus.in_rdy) quiet = 1'b0;
        end
        chk("abort_no_result", 32'(quiet), 32'd1);

        run_op('{9'd400, 4'd3, 9'd133, 4'd1, 1'b0, 0});

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
